cordic_vectoring_iter: RTL and testbench

- Iterative CORDIC in vectoring mode. It is the inverse of the rotation-mode unit.
- It accepts a vector (Xi, Yi) and returns its magnitude and its angle, atan2(Yi, Xi).
- It uses one shared add/shift datapath over I cycles, with valid/ready handshakes on input and output.
- It serves as the polar-conversion companion to the rotation unit in the trig subsystem.
- All data is Q4.28 signed fixed point.

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_vec_step.sv | 38 +++
 rtl/cordic_vectoring_iter.sv | 140 ++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC trig subsystem.
// All values are Q4.28 signed fixed point (1.0 == 0x10000000).
//   PI2 / NPI2 / PI : +pi/2, -pi/2, +pi
//   GAIN_K          : 1/K, the CORDIC gain compensation factor (0.6072529)
//   ATAN_TAB        : atan(2^-i) for i = 0..27, shared with the rotation unit
//   state_t         : iterative engine state encoding
package cordic_pkg;

  localparam logic signed [31:0] PI2    = 32'sh1921FB54;
  localparam logic signed [31:0] NPI2   = 32'shE6DE04AC;
  localparam logic signed [31:0] PI     = 32'sh3243F6A9;
  localparam logic signed [31:0] GAIN_K = 32'sh09B74EDA;

  localparam int ATAN_DEPTH = 28;

  // For i >= 10 the cubic term of atan is below 1 LSB, so entries are 2^(28-i).
  localparam logic signed [31:0] ATAN_TAB [ATAN_DEPTH] = '{
    32'sh0C90FDAA, 32'sh076B19C1, 32'sh03EB6EBF, 32'sh01FD5BA9,
    32'sh00FFAADD, 32'sh007FF557, 32'sh003FFEAB, 32'sh001FFFD5,
    32'sh000FFFFB, 32'sh0007FFFF, 32'sh00040000, 32'sh00020000,
    32'sh00010000, 32'sh00008000, 32'sh00004000, 32'sh00002000,
    32'sh00001000, 32'sh00000800, 32'sh00000400, 32'sh00000200,
    32'sh00000100, 32'sh00000080, 32'sh00000040, 32'sh00000020,
    32'sh00000010, 32'sh00000008, 32'sh00000004, 32'sh00000002
  };

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t PRE  = 3'd1;
  localparam state_t ITER = 3'd2;
  localparam state_t CORR = 3'd3;
  localparam state_t DONE = 3'd4;

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode CORDIC micro-rotation (purely combinational).
// The rotation direction is chosen to drive Y toward zero.
// Ports:
//   x, y, z                   : current vector and accumulated angle
//   shift                     : iteration index i (shift amount)
//   atan_val                  : atan(2^-i) in Q4.28
//   x_next, y_next, z_next    : rotated vector and updated angle
module cordic_vec_step #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] y,
  input  logic signed [N-1:0] z,
  input  logic        [4:0]   shift,
  input  logic signed [N-1:0] atan_val,
  output logic signed [N-1:0] x_next,
  output logic signed [N-1:0] y_next,
  output logic signed [N-1:0] z_next
);

  logic signed [N-1:0] xs;
  logic signed [N-1:0] ys;

  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    if (!y[N-1]) begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan_val;
    end else begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan_val;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: (Xi, Yi) -> magnitude and atan2(Yi, Xi).
// One shared micro-rotation datapath is reused for I cycles.
// Build option: define CORDIC_VEC_GAIN_COMP_EN to add the CORR state that
// multiplies the result by 1/K (latency I+2). Without it, mag is the raw
// CORDIC-scaled X (about 1.64676 * |v|) and latency is I+1.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake for Xi, Yi (Q4.28)
//   out_valid / out_ready : output handshake for mag, angle (Q4.28)
//   mag, angle            : magnitude and angle in (-pi, pi]
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int N = 32,
  parameter int I = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] Xi,
  input  logic signed [N-1:0] Yi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] mag,
  output logic signed [N-1:0] angle
);

  localparam logic [4:0] LAST = 5'(I - 1);

  state_t              state;
  logic signed [N-1:0] x;
  logic signed [N-1:0] y;
  logic signed [N-1:0] z;
  logic        [4:0]   count;
  logic signed [N-1:0] x_step;
  logic signed [N-1:0] y_step;
  logic signed [N-1:0] z_step;
  logic signed [N-1:0] x_upd;
  logic signed [N-1:0] y_upd;
  logic signed [N-1:0] z_upd;
  logic                zero_vec;

  cordic_vec_step #(.N(N)) u_step (
    .x        (x),
    .y        (y),
    .z        (z),
    .shift    (count),
    .atan_val (ATAN_TAB[count]),
    .x_next   (x_step),
    .y_next   (y_step),
    .z_next   (z_step)
  );

  // A zero vector has no direction: freeze it so the angle stays exactly 0
  // instead of accumulating the atan table.
  assign zero_vec = (x == '0) && (y == '0);

  always_comb begin
    x_upd = zero_vec ? x : x_step;
    y_upd = zero_vec ? y : y_step;
    z_upd = zero_vec ? z : z_step;
  end

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int PW = 2 * N;
  logic signed [PW-1:0] prod;
  assign prod = PW'(x) * PW'(GAIN_K);
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      count <= '0;
      mag   <= '0;
      angle <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= Xi;
            y     <= Yi;
            state <= PRE;
          end
        end
        // Quadrant pre-rotation by +/-pi/2 brings the vector into the
        // right half-plane, where the iterations converge.
        PRE: begin
          if (!x[N-1]) begin
            z <= '0;
          end else if (!y[N-1]) begin
            x <= y;
            y <= -x;
            z <= PI2;
          end else begin
            x <= -y;
            y <= x;
            z <= NPI2;
          end
          count <= '0;
          state <= ITER;
        end
        ITER: begin
          x     <= x_upd;
          y     <= y_upd;
          z     <= z_upd;
          count <= count + 5'd1;
          if (count == LAST) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
            state <= CORR;
`else
            mag   <= x_upd;
            angle <= z_upd;
            state <= DONE;
`endif
          end
        end
`ifdef CORDIC_VEC_GAIN_COMP_EN
        // Truncating 64-bit product back to Q4.28.
        CORR: begin
          mag   <= prod[N+27:28];
          angle <= z;
          state <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Testbench for cordic_vectoring_iter: directed, random, backpressure and
// reset scenarios checked against a real-arithmetic atan2/hypot model.
module tb_cordic_vectoring_iter;

  localparam int  N     = 32;
  localparam int  I     = 16;
  localparam real SCALE = 268435456.0;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int  LAT  = I + 2;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = I + 1;
  localparam real GAIN = 1.6467602581210656;
`endif
  localparam longint TOL = (64'sd1 <<< (30 - I)) + 64'sd8;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                in_valid  = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [N-1:0] Xi        = '0;
  logic signed [N-1:0] Yi        = '0;
  logic                in_ready;
  logic                out_valid;
  logic signed [N-1:0] mag;
  logic signed [N-1:0] angle;

  int n_vec = 0;
  int n_err = 0;

  cordic_vectoring_iter #(.N(N), .I(I)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Xi        (Xi),
    .Yi        (Yi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag       (mag),
    .angle     (angle)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Ideal polar conversion, scaled to Q4.28.
  function automatic void ref_model(input int x, input int y,
                                    output longint em, output longint ea);
    real xr;
    real yr;
    xr = real'(x) / SCALE;
    yr = real'(y) / SCALE;
    em = longint'($sqrt(xr * xr + yr * yr) * GAIN * SCALE);
    ea = longint'($atan2(yr, xr) * SCALE);
  endfunction

  function automatic longint absdiff(input logic signed [N-1:0] v, input longint e);
    longint d;
    d = longint'(v) - e;
    return (d < 0) ? -d : d;
  endfunction

  // Presents one vector (caller is 1ns after a rising edge with DUT idle)
  // and waits, bounded, for out_valid. lat counts edges after the accept.
  task automatic apply(input int x, input int y, output int lat,
                       output logic signed [N-1:0] m, output logic signed [N-1:0] a);
    Xi = x;
    Yi = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * I + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    m = mag;
    a = angle;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (mag !== '0) begin n_err++; $display("FAIL reset_mag: got %h want 0", mag); end
    n_vec++; if (angle !== '0) begin n_err++; $display("FAIL reset_angle: got %h want 0", angle); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int vx [5] = '{32'h10000000, 32'h10000000, 32'hF0000000, 0, 0};
    int vy [5] = '{0, 32'h10000000, 0, 32'hF0000000, 0};
    int lat;
    logic signed [N-1:0] m, a;
    longint em, ea, tol;
    for (int k = 0; k < 5; k++) begin
      ref_model(vx[k], vy[k], em, ea);
      tol = (vx[k] == 0 && vy[k] == 0) ? 64'sd0 : TOL;
      apply(vx[k], vy[k], lat, m, a);
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL directed%0d latency: got %0d want %0d", k, lat, LAT); end
      n_vec++; if (absdiff(m, em) > tol) begin n_err++; $display("FAIL directed%0d mag: got %0d want %0d tol %0d", k, m, em, tol); end
      n_vec++; if (absdiff(a, ea) > tol) begin n_err++; $display("FAIL directed%0d angle: got %0d want %0d tol %0d", k, a, ea, tol); end
      release_result();
    end
  endtask

  task automatic test_random();
    int x, y, lat;
    logic signed [N-1:0] m, a;
    longint em, ea;
    for (int k = 0; k < 24; k++) begin
      x = int'($urandom_range(1610612736, 0)) - 805306368;
      y = int'($urandom_range(1610612736, 0)) - 805306368;
      ref_model(x, y, em, ea);
      apply(x, y, lat, m, a);
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL random%0d latency: got %0d want %0d", k, lat, LAT); end
      n_vec++; if (absdiff(m, em) > TOL) begin n_err++; $display("FAIL random%0d mag (%0d,%0d): got %0d want %0d", k, x, y, m, em); end
      n_vec++; if (absdiff(a, ea) > TOL) begin n_err++; $display("FAIL random%0d angle (%0d,%0d): got %0d want %0d", k, x, y, a, ea); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic signed [N-1:0] m, a;
    longint em, ea, em2, ea2;
    ref_model(32'h18000000, 32'hF8000000, em, ea);
    ref_model(32'hE0000000, 32'h0C000000, em2, ea2);
    apply(32'h18000000, 32'hF8000000, lat, m, a);
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL bp latency: got %0d want %0d", lat, LAT); end
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      Xi = 32'h20000000;
      Yi = 32'h20000000;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d out_valid: got %b want 1", k, out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d in_ready: got %b want 0", k, in_ready); end
      n_vec++; if (absdiff(mag, em) > TOL) begin n_err++; $display("FAIL bp%0d mag: got %0d want %0d", k, mag, em); end
      n_vec++; if (absdiff(angle, ea) > TOL) begin n_err++; $display("FAIL bp%0d angle: got %0d want %0d", k, angle, ea); end
    end
    // out_ready and in_valid together in DONE: the vector must wait a cycle.
    Xi = 32'hE0000000;
    Yi = 32'h0C000000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_same_cycle in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept in_ready: got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 4 * I + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL bp2 latency: got %0d want %0d", lat, LAT); end
    n_vec++; if (absdiff(mag, em2) > TOL) begin n_err++; $display("FAIL bp2 mag: got %0d want %0d", mag, em2); end
    n_vec++; if (absdiff(angle, ea2) > TOL) begin n_err++; $display("FAIL bp2 angle: got %0d want %0d", angle, ea2); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic signed [N-1:0] m, a;
    longint em, ea;
    bit seen;
    Xi = 32'h10000000;
    Yi = 32'h08000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset in_ready: got %b want 1", in_ready); end
    n_vec++; if (mag !== '0) begin n_err++; $display("FAIL midreset mag: got %h want 0", mag); end
    n_vec++; if (angle !== '0) begin n_err++; $display("FAIL midreset angle: got %h want 0", angle); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (I + 5) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset aborted result: got out_valid 1 want 0"); end
    ref_model(32'hE8000000, 32'hE0000000, em, ea);
    apply(32'hE8000000, 32'hE0000000, lat, m, a);
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL postreset latency: got %0d want %0d", lat, LAT); end
    n_vec++; if (absdiff(m, em) > TOL) begin n_err++; $display("FAIL postreset mag: got %0d want %0d", m, em); end
    n_vec++; if (absdiff(a, ea) > TOL) begin n_err++; $display("FAIL postreset angle: got %0d want %0d", a, ea); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
